// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes and FSM state types for the AXI4-Lite register slave
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// rtl/axi4_lite_reg_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_wr_ctrl.sv
// rtl/axi4_lite_wr_ctrl.sv - write-channel FSM, byte-strobe merge and register storage
module axi4_lite_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    wr_state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:2]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0]         data_q, data_d;
    logic [STRB_W-1:0]             strb_q, strb_d;
    logic                          commit_q, commit_d;
    logic                          awready_q, awready_d;
    logic                          wready_q, wready_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

    logic             aw_hs;
    logic             w_hs;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             unused_awaddr_lsb;

    // The byte lane within a word never selects a register.
    assign unused_awaddr_lsb = ^awaddr[1:0];

    assign idx          = addr_q[IDX_W+1:2];
    assign out_of_range = |addr_q[ADDR_WIDTH-1:IDX_W+2];

    // Capture address/data as they arrive; the commit happens one cycle after both are held.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        commit_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        aw_hs      = awvalid && awready_q;
        w_hs       = wvalid && wready_q;

        if (aw_hs) addr_d = awaddr[ADDR_WIDTH-1:2];
        if (w_hs) begin
            data_d = wdata;
            strb_d = wstrb;
        end

        unique case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d  = W_RESP;
                    commit_d = 1'b1;
                end else if (aw_hs) begin
                    state_d = W_WAIT_DATA;
                end else if (w_hs) begin
                    state_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: if (w_hs) begin
                state_d  = W_RESP;
                commit_d = 1'b1;
            end
            W_WAIT_ADDR: if (aw_hs) begin
                state_d  = W_RESP;
                commit_d = 1'b1;
            end
            W_RESP: if (bvalid_q && bready) begin
                state_d  = W_IDLE;
                bvalid_d = 1'b0;
            end
            default: state_d = W_IDLE;
        endcase

        // commit_q is only ever set while in W_RESP, so bvalid cannot clash with the exit above.
        if (commit_q) begin
            bvalid_d = 1'b1;
            if (out_of_range) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d         = RESP_OKAY;
                wr_pulse_d[idx] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (strb_q[b]) regs_d[int'(idx)*DATA_WIDTH + b*8 +: 8] = data_q[b*8 +: 8];
                end
            end
        end

        awready_d = (state_d == W_IDLE) || (state_d == W_WAIT_ADDR);
        wready_d  = (state_d == W_IDLE) || (state_d == W_WAIT_DATA);
    end

    // State and registered outputs; readies stay low while reset is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= W_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            commit_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            commit_q   <= commit_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign wr_pulse = wr_pulse_q;
    assign reg_out  = regs_q;
endmodule

// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite slave exposing NUM_REGS read/write registers
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    axi4_lite_reg_slave_if.slave           bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int IDX_W = $clog2(NUM_REGS);

    rd_state_t             rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic             ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic             ar_oor;
    logic             unused_bus_bits;

    // Protection bits and the byte lane of the read address carry no meaning here.
    assign unused_bus_bits = ^{bus.awprot, bus.arprot, bus.araddr[1:0]};

    axi4_lite_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ctrl (
        .clock    (clock),
        .reset_n  (reset_n),
        .awaddr   (bus.awaddr),
        .awvalid  (bus.awvalid),
        .awready  (bus.awready),
        .wdata    (bus.wdata),
        .wstrb    (bus.wstrb),
        .wvalid   (bus.wvalid),
        .wready   (bus.wready),
        .bresp    (bus.bresp),
        .bvalid   (bus.bvalid),
        .bready   (bus.bready),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    assign ar_idx = bus.araddr[IDX_W+1:2];
    assign ar_oor = |bus.araddr[ADDR_WIDTH-1:IDX_W+2];

    // Read path samples the current register contents, so a same-cycle commit is not yet visible.
    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        ar_hs    = bus.arvalid && arready_q;

        unique case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_RESP;
                rvalid_d = 1'b1;
                if (ar_oor) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    rdata_d = reg_out[int'(ar_idx)*DATA_WIDTH +: DATA_WIDTH];
                    rresp_d = RESP_OKAY;
                end
            end
            R_RESP: if (bus.rready) begin
                rstate_d = R_IDLE;
                rvalid_d = 1'b0;
            end
            default: rstate_d = R_IDLE;
        endcase

        arready_d = (rstate_d == R_IDLE);
    end

    // Read FSM state and registered read-channel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - self-checking bench for axi4_lite_reg_slave
module tb_axi4_lite_reg_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    axi4_lite_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    axi4_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [NR];

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a / (NR * 4)) == 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input string tag);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire, inr;
        int idx;
        logic [NR-1:0] exp_pulse;
        logic [1:0] exp_resp, resp0;
        inr = addr_ok(addr);
        idx = int'((addr / 4) % NR);
        exp_pulse = '0;
        if (inr) exp_pulse[idx] = 1'b1;
        exp_resp = inr ? 2'b00 : 2'b10;
        cyc = 0; aw_done = 0; w_done = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(posedge clock); #1;
            cyc++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_checks++;
        if (!(aw_done && w_done)) begin
            n_errors++;
            $display("FAIL %s handshake: aw_done=%0d w_done=%0d required both 1", tag, aw_done, w_done);
            return;
        end
        if (inr) for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        n_checks++;
        if (bus.bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s bvalid_commit_cycle: got %b required 0", tag, bus.bvalid);
        end
        @(posedge clock); #1;
        n_checks++;
        if (bus.bvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s bvalid_latency: got %b required 1", tag, bus.bvalid);
        end
        cyc = 0;
        while (bus.bvalid !== 1'b1 && cyc < 20) begin @(posedge clock); #1; cyc++; end
        if (bus.bvalid !== 1'b1) begin
            n_checks++; n_errors++;
            $display("FAIL %s bvalid_timeout: got %b required 1", tag, bus.bvalid);
            return;
        end
        n_checks++;
        if (bus.bresp !== exp_resp) begin
            n_errors++;
            $display("FAIL %s bresp: got %b required %b", tag, bus.bresp, exp_resp);
        end
        n_checks++;
        if (wr_pulse !== exp_pulse) begin
            n_errors++;
            $display("FAIL %s wr_pulse: got %h required %h", tag, wr_pulse, exp_pulse);
        end
        n_checks++;
        if (reg_out !== model_flat()) begin
            n_errors++;
            $display("FAIL %s reg_out: got %h required %h", tag, reg_out, model_flat());
        end
        resp0 = bus.bresp;
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== resp0) begin
                n_errors++;
                $display("FAIL %s b_hold: bvalid=%b bresp=%b required 1/%b", tag, bus.bvalid, bus.bresp, resp0);
            end
            n_checks++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s ready_in_resp: awready=%b wready=%b required 0/0", tag, bus.awready, bus.wready);
            end
            if (k == 0) begin
                n_checks++;
                if (wr_pulse !== '0) begin
                    n_errors++;
                    $display("FAIL %s wr_pulse_width: got %h required 0", tag, wr_pulse);
                end
            end
        end
        bus.bready = 1'b1;
        @(posedge clock); #1;
        bus.bready = 1'b0;
        n_checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after_b: bvalid=%b awready=%b wready=%b required 0/1/1", tag, bus.bvalid, bus.awready, bus.wready);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly, input string tag);
        int cyc;
        bit fire;
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        exp_data = addr_ok(addr) ? model[(addr / 4) % NR] : 32'h0;
        exp_resp = addr_ok(addr) ? 2'b00 : 2'b10;
        bus.araddr = addr;
        for (int k = 0; k < ar_dly; k++) begin @(posedge clock); #1; end
        bus.arvalid = 1'b1;
        cyc = 0; fire = 0;
        while (!fire && cyc < 20) begin
            fire = bus.arready;
            @(posedge clock); #1;
            cyc++;
        end
        bus.arvalid = 1'b0;
        n_checks++;
        if (!fire || bus.rvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s rvalid: fire=%0d rvalid=%b required 1/1", tag, fire, bus.rvalid);
            return;
        end
        for (int k = 0; k <= r_dly; k++) begin
            n_checks++;
            if (bus.rdata !== exp_data || bus.rresp !== exp_resp || bus.rvalid !== 1'b1) begin
                n_errors++;
                $display("FAIL %s rdata: got %h/%b/%b required %h/%b/1", tag, bus.rdata, bus.rresp, bus.rvalid, exp_data, exp_resp);
            end
            if (k < r_dly) begin @(posedge clock); #1; end
        end
        bus.rready = 1'b1;
        @(posedge clock); #1;
        bus.rready = 1'b0;
        n_checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after_r: rvalid=%b arready=%b required 0/1", tag, bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || wr_pulse !== '0) begin
            n_errors++;
            $display("FAIL reset_valids: bvalid=%b rvalid=%b wr_pulse=%h required 0", bus.bvalid, bus.rvalid, wr_pulse);
        end
        n_checks++;
        if (bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0 || reg_out !== '0) begin
            n_errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h reg_out=%h required 0", bus.bresp, bus.rresp, bus.rdata, reg_out);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1 || bus.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: awready=%b wready=%b arready=%b required 1/1/1", bus.awready, bus.wready, bus.arready);
        end
    endtask

    task automatic test_simultaneous();
        bus.awaddr = 32'h4; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clock); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_checks++;
        if (bus.bvalid !== 1'b0 || wr_pulse !== '0) begin
            n_errors++;
            $display("FAIL sim_cycle1: bvalid=%b wr_pulse=%h required 0/00", bus.bvalid, wr_pulse);
        end
        @(posedge clock); #1;
        model[1] = 32'hDEADBEEF;
        n_checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
            n_errors++;
            $display("FAIL sim_cycle2_b: bvalid=%b bresp=%b required 1/00", bus.bvalid, bus.bresp);
        end
        n_checks++;
        if (wr_pulse !== 8'h02) begin
            n_errors++;
            $display("FAIL sim_pulse: got %h required 02", wr_pulse);
        end
        n_checks++;
        if (reg_out[63:32] !== 32'hDEADBEEF || reg_out !== model_flat()) begin
            n_errors++;
            $display("FAIL sim_reg1: got %h required %h", reg_out, model_flat());
        end
        @(posedge clock); #1;
        n_checks++;
        if (wr_pulse !== '0 || bus.bvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL sim_cycle3: wr_pulse=%h bvalid=%b required 00/1", wr_pulse, bus.bvalid);
        end
        bus.bready = 1'b1;
        @(posedge clock); #1;
        bus.bready = 1'b0;
        n_checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            n_errors++;
            $display("FAIL sim_done: bvalid=%b awready=%b wready=%b required 0/1/1", bus.bvalid, bus.awready, bus.wready);
        end
    endtask

    task automatic test_aw_then_w();
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "aw_w_pre");
        do_write(32'h8, 32'h12345678, 4'h3, 0, 3, 0, "aw_then_w");
        n_checks++;
        if (reg_out[95:64] !== 32'hFFFF5678) begin
            n_errors++;
            $display("FAIL aw_then_w_merge: got %h required FFFF5678", reg_out[95:64]);
        end
    endtask

    task automatic test_w_first_bready_hold();
        do_write(32'h1C, 32'hA5A5_0F0F, 4'hF, 2, 0, 5, "w_first_hold");
    endtask

    task automatic test_out_of_range();
        logic [NR*DW-1:0] snap;
        snap = reg_out;
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1, "oor_write");
        n_checks++;
        if (reg_out !== snap) begin
            n_errors++;
            $display("FAIL oor_unchanged: got %h required %h", reg_out, snap);
        end
        do_read(32'h40, 0, 1, "oor_read");
    endtask

    task automatic test_read_during_commit();
        do_write(32'hC, 32'h11, 4'hF, 0, 0, 0, "rdc_pre");
        bus.awaddr = 32'hC; bus.wdata = 32'h22; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clock); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'hC; bus.arvalid = 1'b1;
        n_checks++;
        if (bus.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL rdc_arready: got %b required 1", bus.arready);
        end
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        model[3] = 32'h22;
        n_checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11) begin
            n_errors++;
            $display("FAIL rdc_old_value: rvalid=%b rdata=%h required 1/00000011", bus.rvalid, bus.rdata);
        end
        n_checks++;
        if (bus.bvalid !== 1'b1 || reg_out[127:96] !== 32'h22) begin
            n_errors++;
            $display("FAIL rdc_commit: bvalid=%b reg3=%h required 1/00000022", bus.bvalid, reg_out[127:96]);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clock); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(32'hC, 0, 0, "rdc_new_value");
    endtask

    task automatic test_wstrb_zero();
        do_write(32'h14, 32'h5555AAAA, 4'h0, 0, 0, 0, "wstrb_zero");
    endtask

    task automatic test_reset_mid();
        bus.awaddr = 32'hC; bus.awvalid = 1'b1;
        @(posedge clock); #1;
        bus.awvalid = 1'b0;
        n_checks++;
        if (bus.awready !== 1'b0 || bus.wready !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_wait_data: awready=%b wready=%b required 0/1", bus.awready, bus.wready);
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        clear_model();
        n_checks++;
        if (reg_out !== '0 || bus.bvalid !== 1'b0 || wr_pulse !== '0) begin
            n_errors++;
            $display("FAIL rmid_in_reset: reg_out=%h bvalid=%b wr_pulse=%h required 0", reg_out, bus.bvalid, wr_pulse);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.bvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL rmid_no_resp: bvalid=%b required 0", bus.bvalid);
            end
        end
        do_write(32'hC, 32'h0BADF00D, 4'hF, 0, 1, 1, "rmid_after");
        do_read(32'hC, 0, 0, "rmid_read");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            addr = 32'($urandom_range(0, 9)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(5, 31));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), "rand_write");
            else
                do_read(addr, $urandom_range(0, 2), $urandom_range(0, 2), "rand_read");
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        test_reset();
        test_simultaneous();
        test_aw_then_w();
        test_w_first_bready_hold();
        test_out_of_range();
        test_read_during_commit();
        test_wstrb_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 ADDR_WIDTH, 32, AXI address width.
REQ-002 DATA_WIDTH, 32, AXI data width; only 32 supported.
REQ-003 NUM_REGS, 8, number of RW registers; power of two, 2..64.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock; all logic rising-edge.
REQ-006 reset_n  in  1  async assert, active-low.
REQ-007 awaddr  in  ADDR_WIDTH  write address.
REQ-008 awprot  in  3  ignored.
REQ-009 awvalid/awready  in/out  1  write-address handshake.
REQ-010 wdata  in  DATA_WIDTH  write data.
REQ-011 wstrb  in  DATA_WIDTH/8  byte enables.
REQ-012 wvalid/wready  in/out  1  write-data handshake.
REQ-013 bresp  out  2  write response.
REQ-014 bvalid/bready  out/in  1  write-response handshake.
REQ-015 araddr  in  ADDR_WIDTH  read address.
REQ-016 arprot  in  3  ignored.
REQ-017 arvalid/arready  in/out  1  read-address handshake.
REQ-018 rdata  out  DATA_WIDTH  read data.
REQ-019 rresp  out  2  read response.
REQ-020 rvalid/rready  out/in  1  read-data handshake.
REQ-021 reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [32i+31:32i].
REQ-022 wr_pulse  out  NUM_REGS  one-hot, one-cycle pulse per committed write.

Function
REQ-023 Decode: index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; any set bit above the index field = out of range.
REQ-024 Write FSM states: W_IDLE, W_WAIT_DATA (addr held), W_WAIT_ADDR (data held), W_RESP.
REQ-025 awready=1 in W_IDLE and W_WAIT_ADDR; wready=1 in W_IDLE and W_WAIT_DATA; both 0 in W_RESP.
REQ-026 W_IDLE: AW and W in the same cycle -> commit, go to W_RESP; AW only -> W_WAIT_DATA; W only -> W_WAIT_ADDR.
REQ-027 Commit: each byte with wstrb set is updated, other bytes kept; wr_pulse[index] asserts in the cycle after commit; bvalid rises in the cycle after commit.
REQ-028 Out-of-range write: no register change, no wr_pulse, bresp=2'b10 (SLVERR); otherwise bresp=2'b00.
REQ-029 bvalid and bresp are held stable until bready; bvalid&&bready -> W_IDLE, and a new AW/W is accepted no earlier than the next cycle.
REQ-030 Read FSM states: R_IDLE (arready=1), R_RESP (arready=0); arvalid in R_IDLE -> rdata/rresp registered, rvalid=1 next cycle.
REQ-031 Out-of-range read: rdata=0, rresp=2'b10; rdata/rresp held until rvalid&&rready, then R_IDLE.
REQ-032 Read and write channels are independent; a read accepted in the same cycle as a write commit to the same register returns the pre-write value.
REQ-033 wstrb=0 with a valid address: response OKAY; wr_pulse asserts; contents unchanged.

Reset
REQ-034 reset_n low: both FSMs idle; all registers 0; bvalid, rvalid, wr_pulse 0; bresp, rresp, rdata 0; awready, wready, arready 1 one cycle after deassertion.
REQ-035 Reset mid-transaction drops the outstanding transaction; no response is issued after reset.

Structure
REQ-036 Shared package axi4_lite_pkg: RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, the write-FSM and read-FSM state enums.
REQ-037 Single sub-module axi4_lite_wr_ctrl (write FSM plus strobe merge); the read path stays inline.

Verification
REQ-038 AW+W in the same cycle, addr 0x04, data 0xDEADBEEF, wstrb 0xF -> bvalid two cycles after the handshake cycle, bresp 0; reg 1 = 0xDEADBEEF; wr_pulse=8'h02 for one cycle.
REQ-039 AW at cycle N, W at N+3, addr 0x08, wstrb 0x3, data 0x12345678 over reg 2 = 0xFFFFFFFF -> reg 2 = 0xFFFF5678.
REQ-040 W before AW, bready held low for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout.
REQ-041 Write addr 0x40 (NUM_REGS=8) -> bresp 2'b10, registers unchanged; read 0x40 -> rdata 0, rresp 2'b10.
REQ-042 Read reg 3 in the same cycle as a write commit to reg 3 (old 0x11, new 0x22) -> rdata 0x11; a subsequent read returns 0x22.
REQ-043 reset_n pulsed low while in W_WAIT_DATA -> no bvalid is issued; all registers 0; the next full write completes normally.
